// File: rtl/arbitro_controle.sv
// -----------------------------------------------------------------------------
// arbitro_controle
//
// Two-requester round-robin arbiter that launches one job at a time on a shared
// datapath controller and returns the result to whichever requester won.
//
// Job flow: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
// Every output is decoded from registers (Moore).
//
// Handshake semantics (one rule for every interface of this block):
//   * reqN is a level request. The requester holds it until it sees gntN.
//   * xN is sampled only on the edge where requester N wins arbitration.
//   * dp_start is a one-cycle pulse. It is issued only when the datapath
//     reported dp_ready while the block was in IDLE.
//   * dp_valid/dp_result are sampled only in WAIT. dp_valid is ignored in
//     every other state.
//   * doneN is a one-cycle pulse. err is qualified by the same pulse.
//
// Ports
//   clock, reset          : single clock; asynchronous active-high reset
//   req0/req1, x0/x1      : requests and their operands
//   gnt0/gnt1             : one-cycle grant pulses
//   done0/done1, res, err : completion pulse, last result, timeout flag
//   busy                  : high whenever the FSM is not in IDLE
//   dp_ready, dp_start,
//   dp_x, dp_valid,
//   dp_result             : datapath controller interface
//   dbg_state             : FSM state (0=IDLE 1=LAUNCH 2=WAIT 3=DONE)
// -----------------------------------------------------------------------------
module arbitro_controle #(
    parameter int W       = 8,
    parameter int RW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [W-1:0]  x0,
    input  logic [W-1:0]  x1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [RW-1:0] res,
    output logic          err,
    output logic          busy,
    input  logic          dp_ready,
    output logic          dp_start,
    output logic [W-1:0]  dp_x,
    input  logic          dp_valid,
    input  logic [RW-1:0] dp_result,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT);

    state_t        state_q,  state_d;
    logic          ptr_q,    ptr_d;
    logic          owner_q,  owner_d;
    logic [7:0]    timer_q,  timer_d;
    logic [W-1:0]  dp_x_q,   dp_x_d;
    logic [RW-1:0] res_q,    res_d;
    logic          err_q,    err_d;

    logic          any_req;
    logic          winner;

    // A lone request always wins. On a tie, the pointer picks the winner.
    assign any_req = req0 | req1;
    assign winner  = (req0 & req1) ? ptr_q : req1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            timer_q <= 8'd0;
            dp_x_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            dp_x_q  <= dp_x_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        timer_d = timer_q;
        dp_x_d  = dp_x_q;
        res_d   = res_q;
        // err lives only for the DONE cycle, so it drops by default.
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dp_ready && any_req) begin
                    state_d = ST_LAUNCH;
                    owner_d = winner;
                    dp_x_d  = winner ? x1 : x0;
                    timer_d = 8'd0;
                end
            end

            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A valid result wins over a timeout that expires in the same cycle.
                if (dp_valid) begin
                    state_d = ST_DONE;
                    res_d   = dp_result;
                    err_d   = 1'b0;
                end else if (timer_q == TIMER_MAX) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                // The requester just served drops to lowest priority. This also
                // applies after a timed-out job.
                ptr_d   = ~owner_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (registers only)
    // -------------------------------------------------------------------------
    always_comb begin
        gnt0      = (state_q == ST_LAUNCH) && !owner_q;
        gnt1      = (state_q == ST_LAUNCH) &&  owner_q;
        dp_start  = (state_q == ST_LAUNCH);
        done0     = (state_q == ST_DONE)   && !owner_q;
        done1     = (state_q == ST_DONE)   &&  owner_q;
        busy      = (state_q != ST_IDLE);
        res       = res_q;
        err       = err_q;
        dp_x      = dp_x_q;
        dbg_state = state_q;
    end

endmodule
